// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem req/ack, prefetch FIFO to the decoder.
// Optional FETCH_STATS_EN adds stat_fetched / stat_flushed counters.
module fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        dec_valid,
   output logic [31:0] dec_instr,
   output logic [31:0] dec_pc,
   input  logic        dec_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0] stat_fetched,
   output logic [31:0] stat_flushed
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DRAIN
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   addr_q, addr_d;
   logic          req_q, req_d;
   logic [31:0]   instr_mem_q [DEPTH];
   logic [31:0]   instr_mem_d [DEPTH];
   logic [31:0]   pc_mem_q [DEPTH];
   logic [31:0]   pc_mem_d [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic          push;
   logic          pop;
   logic [CW-1:0] occupancy;
   logic          unused_pc_bits;

   assign unused_pc_bits = ^redirect_pc[1:0];

   // Decoder handshake: a word transfers on any edge where dec_valid && dec_ready;
   // dec_valid never depends on dec_ready, and the head holds until it transfers.
   assign dec_valid = (count_q != '0);
   assign dec_instr = instr_mem_q[rd_ptr_q];
   assign dec_pc    = pc_mem_q[rd_ptr_q];
   assign imem_req  = req_q;
   assign imem_addr = addr_q;

   always_comb begin
      push        = (state_q == ST_WAIT) && imem_ack && !redirect;
      pop         = dec_valid && dec_ready;
      occupancy   = count_q + CW'(state_q == ST_WAIT);
      state_d     = state_q;
      pc_d        = pc_q;
      addr_d      = addr_q;
      req_d       = req_q;
      instr_mem_d = instr_mem_q;
      pc_mem_d    = pc_mem_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;

      if (redirect) begin
         // Redirect wins: flush, retarget, and mark any outstanding request for discard.
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         pc_d     = {redirect_pc[31:2], 2'b00};
         if (state_q != ST_IDLE) begin
            if (imem_ack) begin
               state_d = ST_IDLE;
               req_d   = 1'b0;
            end else begin
               state_d = ST_DRAIN;
            end
         end
      end else begin
         if (push) begin
            instr_mem_d[wr_ptr_q] = imem_rdata;
            pc_mem_d[wr_ptr_q]    = pc_q;
            wr_ptr_d              = wr_ptr_q + AW'(1);
            pc_d                  = pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);

         case (state_q)
            ST_IDLE: begin
               if (occupancy < DEPTH_C) begin
                  state_d = ST_WAIT;
                  req_d   = 1'b1;
                  addr_d  = pc_q;
               end
            end
            ST_WAIT, ST_DRAIN: begin
               if (imem_ack) begin
                  state_d = ST_IDLE;
                  req_d   = 1'b0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               req_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         addr_q   <= RESET_PC;
         req_q    <= 1'b0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_mem_q[i] <= '0;
            pc_mem_q[i]    <= '0;
         end
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         addr_q      <= addr_d;
         req_q       <= req_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         instr_mem_q <= instr_mem_d;
         pc_mem_q    <= pc_mem_d;
      end
   end

`ifdef FETCH_STATS_EN
   logic [31:0] stat_fetched_q, stat_fetched_d;
   logic [31:0] stat_flushed_q, stat_flushed_d;
   logic        discard;

   always_comb begin
      // A head accepted in the redirect cycle counts as consumed, not discarded.
      discard        = (state_q == ST_WAIT) || (count_q != CW'(pop));
      stat_fetched_d = stat_fetched_q + 32'(push);
      stat_flushed_d = stat_flushed_q + 32'(redirect && discard);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_fetched_q <= '0;
         stat_flushed_q <= '0;
      end else begin
         stat_fetched_q <= stat_fetched_d;
         stat_flushed_q <= stat_flushed_d;
      end
   end

   assign stat_fetched = stat_fetched_q;
   assign stat_flushed = stat_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, directed corner sequences, and a random run
// scored against a stream-level model of the words the decoder must see.
module tb_fetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] KEY      = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        dec_valid;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic        dec_ready = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
`ifdef FETCH_STATS_EN
   logic [31:0] stat_fetched;
   logic [31:0] stat_flushed;
`endif

   always #5 clk = ~clk;

   fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .dec_valid   (dec_valid),
      .dec_instr   (dec_instr),
      .dec_pc      (dec_pc),
      .dec_ready   (dec_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
`ifdef FETCH_STATS_EN
      ,
      .stat_fetched(stat_fetched),
      .stat_flushed(stat_flushed)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Scoreboard: {instr, pc} of every word the decoder is still owed.
   logic [63:0] exp_q[$];
   logic [31:0] fetch_pc;
   bit          stale;
   logic [31:0] stale_addr;
   bit          model_on;
   int          pop_count;

   bit mem_auto;
   int mem_lat_max;
   int ack_budget;
   int wait_cnt;
   int cur_lat;
   int ack_count;

   typedef struct {
      bit          rdy;
      bit          redir;
      logic [31:0] rpc;
      bit          ack;
      bit          e_req;
      logic [31:0] e_addr;
      bit          e_valid;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vecs[19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_update();
      bit pop_now;
      logic [63:0] head;
      pop_now = dec_valid && dec_ready;
      if (pop_now && exp_q.size() != 0) begin
         head = exp_q.pop_front();
         check("pop_pc", dec_pc, head[31:0]);
         check("pop_instr", dec_instr, head[63:32]);
         pop_count++;
      end
      if (imem_req && !stale) check("req_addr", imem_addr, fetch_pc);
      if (imem_req && stale) check("drain_addr_hold", imem_addr, stale_addr);
      if (redirect) begin
         exp_q.delete();
         fetch_pc = {redirect_pc[31:2], 2'b00};
         if (!stale && imem_req && !imem_ack) stale_addr = imem_addr;
         stale = imem_req && !imem_ack;
      end else if (imem_req && imem_ack) begin
         if (!stale) begin
            exp_q.push_back({fetch_pc ^ KEY, fetch_pc});
            fetch_pc = fetch_pc + 32'd4;
         end
         stale = 1'b0;
      end
   endtask

   task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc, input bit tbl_ack);
      dec_ready   = rdy;
      redirect    = redir;
      redirect_pc = rpc;
      if (mem_auto) begin
         if (imem_req) begin
            if (wait_cnt == 0) cur_lat = $urandom_range(1, mem_lat_max);
            wait_cnt++;
            if (wait_cnt >= cur_lat && ack_budget != 0) begin
               imem_ack   = 1'b1;
               imem_rdata = imem_addr ^ KEY;
               wait_cnt   = 0;
               if (ack_budget > 0) ack_budget--;
            end else begin
               imem_ack   = 1'b0;
               imem_rdata = $urandom();
            end
         end else begin
            imem_ack = 1'b0;
            wait_cnt = 0;
         end
      end else begin
         imem_ack   = tbl_ack;
         imem_rdata = imem_addr ^ KEY;
      end
      if (imem_req && imem_ack) ack_count++;
      if (model_on) model_update();
      @(posedge clk);
      @(negedge clk);
      if (model_on) begin
         check("dec_valid_vs_model", dec_valid, exp_q.size() != 0);
         check("occupancy_bound", (exp_q.size() + int'(imem_req && !stale)) <= DEPTH, 1);
      end
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      dec_ready   = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      imem_ack    = 1'b0;
      imem_rdata  = '0;
      @(posedge clk);
      @(negedge clk);
      check("rst_req", imem_req, 0);
      check("rst_addr", imem_addr, RESET_PC);
      check("rst_valid", dec_valid, 0);
      check("rst_instr", dec_instr, 0);
      check("rst_pc", dec_pc, 0);
`ifdef FETCH_STATS_EN
      check("rst_stat_fetched", stat_fetched, 0);
      check("rst_stat_flushed", stat_flushed, 0);
`endif
      exp_q.delete();
      fetch_pc    = RESET_PC;
      stale       = 1'b0;
      stale_addr  = '0;
      pop_count   = 0;
      wait_cnt    = 0;
      ack_count   = 0;
      ack_budget  = -1;
      mem_lat_max = 1;
      rst         = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int reqs;
      int gap;
      int max_gap;
      bit seen_valid;
      bit prev_req;
      bit found;
      int pct;

      vecs[0]  = '{1, 0, 32'h0,   0, 1, 32'h0,   0, 32'h0};
      vecs[1]  = '{1, 0, 32'h0,   1, 0, 32'h0,   1, 32'h0};
      vecs[2]  = '{1, 0, 32'h0,   0, 1, 32'h4,   0, 32'h0};
      vecs[3]  = '{1, 0, 32'h0,   1, 0, 32'h0,   1, 32'h4};
      vecs[4]  = '{0, 0, 32'h0,   0, 1, 32'h8,   1, 32'h4};
      vecs[5]  = '{0, 0, 32'h0,   0, 1, 32'h8,   1, 32'h4};
      vecs[6]  = '{0, 1, 32'h103, 0, 1, 32'h8,   0, 32'h0};
      vecs[7]  = '{0, 0, 32'h0,   0, 1, 32'h8,   0, 32'h0};
      vecs[8]  = '{0, 0, 32'h0,   1, 0, 32'h0,   0, 32'h0};
      vecs[9]  = '{1, 0, 32'h0,   0, 1, 32'h100, 0, 32'h0};
      vecs[10] = '{1, 0, 32'h0,   1, 0, 32'h0,   1, 32'h100};
      vecs[11] = '{1, 0, 32'h0,   0, 1, 32'h104, 0, 32'h0};
      vecs[12] = '{1, 1, 32'h200, 1, 0, 32'h0,   0, 32'h0};
      vecs[13] = '{1, 0, 32'h0,   0, 1, 32'h200, 0, 32'h0};
      vecs[14] = '{1, 0, 32'h0,   1, 0, 32'h0,   1, 32'h200};
      vecs[15] = '{0, 0, 32'h0,   0, 1, 32'h204, 1, 32'h200};
      vecs[16] = '{1, 1, 32'h300, 1, 0, 32'h0,   0, 32'h0};
      vecs[17] = '{1, 0, 32'h0,   0, 1, 32'h300, 0, 32'h0};
      vecs[18] = '{1, 0, 32'h0,   1, 0, 32'h0,   1, 32'h300};

      // Vector table: startup, drain after redirect, redirect with ack and pop.
      mem_auto = 0;
      model_on = 0;
      @(negedge clk);
      do_reset();
      for (int i = 0; i < 19; i++) begin
         step(vecs[i].rdy, vecs[i].redir, vecs[i].rpc, vecs[i].ack);
         check($sformatf("vec%0d_req", i), imem_req, vecs[i].e_req);
         if (vecs[i].e_req) check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_addr);
         check($sformatf("vec%0d_valid", i), dec_valid, vecs[i].e_valid);
         if (vecs[i].e_valid) begin
            check($sformatf("vec%0d_pc", i), dec_pc, vecs[i].e_pc);
            check($sformatf("vec%0d_instr", i), dec_instr, vecs[i].e_pc ^ KEY);
         end
      end

      // Asynchronous reset while a request is outstanding and the FIFO holds a word.
      do_reset();
      step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      check("pre_areset_req", imem_req, 1);
      check("pre_areset_valid", dec_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("areset_req", imem_req, 0);
      check("areset_addr", imem_addr, RESET_PC);
      check("areset_valid", dec_valid, 0);
      check("areset_instr", dec_instr, 0);
      check("areset_pc", dec_pc, 0);
      @(negedge clk);

      // Streaming with 1-cycle memory and an always-ready decoder.
      mem_auto = 1;
      model_on = 1;
      do_reset();
      max_gap = 0;
      gap = 0;
      seen_valid = 0;
      for (int i = 0; i < 40; i++) begin
         step(1, 0, 0, 0);
         if (dec_valid) begin
            seen_valid = 1;
            gap = 0;
         end else if (seen_valid) begin
            gap++;
            if (gap > max_gap) max_gap = gap;
         end
      end
      check("stream_pops", pop_count, 19);
      check("stream_max_gap", max_gap, 1);

      // Back-pressure: FIFO fills, then one freed slot allows exactly one fetch.
      do_reset();
      for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
      check("bp_acks", ack_count, DEPTH);
      check("bp_req_idle", imem_req, 0);
      prev_req = imem_req;
      reqs = 0;
      for (int i = 0; i < 11; i++) begin
         step(i == 0, 0, 0, 0);
         if (imem_req && !prev_req) reqs++;
         prev_req = imem_req;
      end
      check("bp_one_request", reqs, 1);
      check("bp_total_acks", ack_count, DEPTH + 1);

      // PC wrap at the top of the address space; low redirect bits ignored.
      do_reset();
      step(1, 1, 32'hFFFF_FFFF, 0);
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         step(1, 0, 0, 0);
         if (imem_req && imem_addr != 32'hFFFF_FFFC) found = 1;
      end
      check("wrap_found", found, 1);
      check("wrap_addr", imem_addr, 32'h0);

`ifdef FETCH_STATS_EN
      do_reset();
      step(0, 1, 32'h0, 0);
      check("stat_idle_redirect", stat_flushed, 0);
      for (int i = 0; i < 12; i++) step(0, 0, 0, 0);
      check("stat_fetched_full", stat_fetched, DEPTH);
      step(0, 1, 32'h40, 0);
      check("stat_flushed_one", stat_flushed, 1);
      ack_budget = 6;
      for (int i = 0; i < 40 && ack_budget > 0; i++) step(1, 0, 0, 0);
      check("stat_budget_used", ack_budget, 0);
      check("stat_fetched_ten", stat_fetched, 10);
      check("stat_flushed_still_one", stat_flushed, 1);
`endif

      // Random run against the stream model.
      do_reset();
      mem_lat_max = 3;
      for (int i = 0; i < 2400; i++) begin
         case ((i / 300) % 3)
            0:       pct = 15;
            1:       pct = 60;
            default: pct = 95;
         endcase
         step($urandom_range(0, 99) < pct, $urandom_range(0, 15) == 0,
              ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom(),
              0);
      end
      check("random_progress", pop_count > 100, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
